// File: rtl/cdc_pkg.sv
// Shared types for the req/ack CDC handshake source.
// Holds the handshake FSM encoding and the synchronizer depth floor.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } cdc_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop async-reset level synchronizer; latency STAGES clk edges, no backpressure.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  // Depth below two gives no metastability settling window, so it is floored.
  localparam int unsigned N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] pipe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[N-2:0], d_i};
    end
  end

  assign q_o = pipe_q[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing; round trip 2*(SYNC_STAGES+1) edges plus far-side delay.
// in_ready drops for the whole handshake and while a stale ack is still seen high.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  cdc_data,
  output logic                   cdc_req,
  input  logic                   cdc_ack,
  output logic                   done,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYCLES);

  cdc_state_e             state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] xfer_q, xfer_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   ack_sync;
  logic                   waiting;
  logic                   timeout_hit;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (cdc_ack),
    .q_o     (ack_sync)
  );

  // A high ack_sync in IDLE means the far side has not released yet.
  assign in_ready = (state_q == IDLE) && !ack_sync;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    xfer_d  = xfer_q;
    waiting = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end else begin
          waiting = 1'b1;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
          xfer_d  = xfer_q + COUNT_WIDTH'(1);
        end else begin
          waiting = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) begin
      wcnt_d = '0;
    end else if (waiting && (wcnt_q != WCNT_MAX)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
    // Flags on the edge the counter reaches the limit; stays asserted while saturated.
    timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && (wcnt_d == WCNT_MAX);
    err_d = err_q;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign cdc_data    = data_q;
  assign cdc_req     = req_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: loopback latency, back-to-back, timeout, stale ack, reset, wrap.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cdc_data;
  logic       cdc_req;
  logic       cdc_ack;
  logic       done;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;
  logic [3:0] xfer_count;

  logic       lb_en;
  logic       ack_force;
  logic       req_prev;
  int         cyc;
  int         n_checks;
  int         n_errors;
  logic [7:0] rx_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;

  // Far side: zero-delay loopback, or a level the bench drives directly.
  assign cdc_ack = lb_en ? cdc_req : ack_force;

  cdc_handshake_tx #(
    .DATA_WIDTH     (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16),
    .COUNT_WIDTH    (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cdc_data    (cdc_data),
    .cdc_req     (cdc_req),
    .cdc_ack     (cdc_ack),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .xfer_count  (xfer_count)
  );

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  initial req_prev = 1'b0;
  always @(negedge clk) begin
    if (cdc_req && !req_prev) rx_q.push_back(cdc_data);
    req_prev <= cdc_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic send(input logic [7:0] d);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_ready_wait", 32'd0, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int  idx;
    logic acc;
    n_checks  = 0;
    n_errors  = 0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    lb_en     = 1'b1;
    ack_force = 1'b0;
    reset_n   = 1'b0;
    step(2);
    chk("rst_req", cdc_req, 1'b0);
    chk("rst_data", cdc_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_xfer", xfer_count, 4'd0);
    chk("rst_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    step(1);

    // Loopback latency for a single word
    send(8'hA5);
    chk("lat_req_rise", cdc_req, 1'b1);
    chk("lat_data", cdc_data, 8'hA5);
    chk("lat_busy", busy, 1'b1);
    chk("lat_ready_busy", in_ready, 1'b0);
    step(2);
    chk("lat_req_c3", cdc_req, 1'b1);
    step(1);
    chk("lat_req_fall_c4", cdc_req, 1'b0);
    chk("lat_data_held", cdc_data, 8'hA5);
    step(2);
    chk("lat_done_c6", done, 1'b0);
    step(1);
    chk("lat_done_c7", done, 1'b1);
    chk("lat_xfer", xfer_count, 4'd1);
    chk("lat_ready_c7", in_ready, 1'b1);
    step(1);
    chk("lat_done_pulse", done, 1'b0);

    // Back-to-back with in_valid held; junk on in_data while busy
    rx_q.delete();
    acc_q.delete();
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      acc = in_ready;
      in_data = acc ? 8'(idx + 1) : 8'(8'hC0 + c);
      @(negedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    wait_done("b2b_done");
    step(2);
    chk("b2b_accepts", acc_q.size(), 4);
    for (int i = 1; i < 4 && i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], 7);
    chk("b2b_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      chk("b2b_rx_word", rx_q[i], i + 1);
    chk("b2b_xfer", xfer_count, 4'd5);

    // No ack: timeout after 16 wait cycles, then late completion and clear
    lb_en = 1'b0;
    ack_force = 1'b0;
    send(8'h96);
    step(15);
    chk("to_err_c16", timeout_err, 1'b0);
    step(1);
    chk("to_err_c17", timeout_err, 1'b1);
    chk("to_req_held", cdc_req, 1'b1);
    chk("to_data_held", cdc_data, 8'h96);
    ack_force = 1'b1;
    step(4);
    chk("to_req_fall", cdc_req, 1'b0);
    ack_force = 1'b0;
    wait_done("to_done");
    chk("to_xfer", xfer_count, 4'd6);
    chk("to_err_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 1'b0);

    // Ack pulse that never straddles a clock edge
    ack_force = 1'b1;
    #2;
    ack_force = 1'b0;
    step(3);
    chk("glitch_ready", in_ready, 1'b1);
    chk("glitch_busy", busy, 1'b0);

    // Stale ack high across reset release
    reset_n = 1'b0;
    ack_force = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("stale_ready", in_ready, 1'b0);
    in_data  = 8'h77;
    in_valid = 1'b1;
    step(3);
    chk("stale_busy", busy, 1'b0);
    chk("stale_req", cdc_req, 1'b0);
    in_valid  = 1'b0;
    ack_force = 1'b0;
    step(1);
    chk("stale_ready_c1", in_ready, 1'b0);
    step(1);
    chk("stale_ready_c2", in_ready, 1'b1);
    lb_en = 1'b1;
    rx_q.delete();
    send(8'h5A);
    wait_done("stale_done");
    chk("stale_xfer", xfer_count, 4'd1);
    chk("stale_rx", (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00, 8'h5A);

    // Reset while waiting for ack high
    lb_en = 1'b0;
    send(8'hC3);
    step(1);
    chk("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_req", cdc_req, 1'b0);
    chk("mid_data", cdc_data, 8'h00);
    chk("mid_busy_rst", busy, 1'b0);
    chk("mid_xfer", xfer_count, 4'd0);
    step(1);
    reset_n = 1'b1;
    lb_en = 1'b1;
    step(2);
    send(8'h3C);
    chk("mid_resend_data", cdc_data, 8'h3C);
    wait_done("mid_resend_done");
    chk("mid_resend_xfer", xfer_count, 4'd1);

    // Counter wrap: from 1, fourteen more words reach all-ones, one more wraps
    for (int i = 0; i < 14; i++) begin
      send(8'(i));
      wait_done("wrap_done");
    end
    chk("wrap_all_ones", xfer_count, 4'hF);
    send(8'hFF);
    wait_done("wrap_last_done");
    chk("wrap_zero", xfer_count, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
